// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC generation, SRAM-like fetch port, IF/ID handoff
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          IF_TO_ID_WD = 33,
  parameter int          BR_WD       = 33,
  parameter int          STALL_WD    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            if_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic        br_pend;
  logic [31:0] br_tgt;

  logic        br_e;
  logic [31:0] br_addr;
  logic        valid;
  logic        handoff;
  logic [31:0] next_pc;
  logic        unused_stall;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign unused_stall = ^stall[STALL_WD-1:2];

  // Outputs are forced low while rst is held so ID never sees a half-reset fetch.
  assign valid     = ~rst & (((state == S_WAIT) & inst_data_ok) | (state == S_HOLD));
  assign handoff   = valid & ~stall[1];
  assign inst_req  = ~rst & (state == S_REQ) & ~stall[0];
  assign inst_addr = pc;

  assign if_to_id_bus = valid ? {1'b1, pc} : '0;
  assign if_inst      = (valid && state == S_HOLD) ? inst_buf :
                        (valid ? inst_rdata : 32'b0);

  // A branch seen together with the delay-slot handoff redirects directly.
  assign next_pc = br_e    ? br_addr :
                   br_pend ? br_tgt  : pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst_buf <= 32'b0;
      br_pend  <= 1'b0;
      br_tgt   <= 32'b0;
    end else begin
      if (handoff) begin
        pc      <= next_pc;
        br_pend <= 1'b0;
      end else if (br_e) begin
        br_pend <= 1'b1;
        br_tgt  <= br_addr;
      end

      case (state)
        S_REQ: begin
          if (inst_req && inst_addr_ok) state <= S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (stall[1]) begin
              inst_buf <= inst_rdata;
              state    <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall[1]) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized bench for if_fetch against a program-order fetch model
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;

  int n_checks = 0;
  int n_fail   = 0;
  int handoffs = 0;

  // Reference model: architectural fetch stream plus memory-side bookkeeping.
  logic [31:0] exp_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  bit          outstanding;
  logic [31:0] out_addr;
  bit          held;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_bus       (br_bus),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_to_id_bus (if_to_id_bus),
    .if_inst      (if_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C01_1234;
  endfunction

  task automatic model_reset();
    exp_pc      = RESET_PC;
    m_pend      = 1'b0;
    m_tgt       = 32'b0;
    outstanding = 0;
    out_addr    = 32'b0;
    held        = 0;
  endtask

  task automatic drive_rand();
    logic [31:0] r;
    logic [5:0]  s;
    r = $urandom;
    r[1:0] = 2'b00;
    s = 6'($urandom);
    s[0] = ($urandom % 4 == 0);
    s[1] = ($urandom % 3 == 0);
    stall        = s;
    br_bus       = {($urandom % 6 == 0), r};
    inst_addr_ok = ($urandom % 3 != 0);
    inst_data_ok = outstanding && ($urandom % 3 != 0);
    inst_rdata   = inst_data_ok ? mem_word(out_addr) : $urandom;
  endtask

  // Compare the current cycle's outputs with the model, then advance the model.
  task automatic step();
    bit exp_req, exp_ce, hand;
    exp_req = !outstanding && !held && !stall[0];
    check("inst_req", 64'(inst_req), 64'(exp_req));
    if (exp_req) check("inst_addr", 64'(inst_addr), 64'(exp_pc));
    exp_ce = (outstanding && inst_data_ok) || held;
    check("ce", 64'(if_to_id_bus[32]), 64'(exp_ce));
    if (exp_ce) begin
      check("pc", 64'(if_to_id_bus[31:0]), 64'(exp_pc));
      check("if_inst", 64'(if_inst), 64'(mem_word(exp_pc)));
    end else begin
      check("bus_idle", 64'(if_to_id_bus), 64'd0);
      check("inst_idle", 64'(if_inst), 64'd0);
    end
    hand = exp_ce && !stall[1];
    if (exp_req && inst_addr_ok) begin
      outstanding = 1;
      out_addr    = exp_pc;
    end else if (outstanding && inst_data_ok) begin
      outstanding = 0;
      if (stall[1]) held = 1;
    end
    if (hand) begin
      held = 0;
      handoffs++;
      exp_pc = br_bus[32] ? br_bus[31:0] : (m_pend ? m_tgt : exp_pc + 32'd4);
      m_pend = 1'b0;
    end else if (br_bus[32]) begin
      m_pend = 1'b1;
      m_tgt  = br_bus[31:0];
    end
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      drive_rand();
      #3;
      step();
    end
  endtask

  initial begin
    rst          = 1'b1;
    stall        = '0;
    br_bus       = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    #3;
    check("rst_req", 64'(inst_req), 64'd0);
    check("rst_bus", 64'(if_to_id_bus), 64'd0);
    check("rst_inst", 64'(if_inst), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #3;
    check("first_addr", 64'(inst_addr), 64'(RESET_PC));
    check("first_req", 64'(inst_req), 64'd1);

    run_random(3000);

    // Steer into WAIT with a captured branch, then reset asynchronously.
    for (int i = 0; i < 50 && !outstanding; i++) begin
      @(posedge clk);
      #1;
      stall = '0; br_bus = '0; inst_addr_ok = 1'b1; inst_data_ok = 1'b0;
      #3;
      step();
    end
    check("reach_wait", 64'(outstanding), 64'd1);
    @(posedge clk);
    #1;
    stall = '0; br_bus = {1'b1, 32'h0000_1000}; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #3;
    step();
    @(posedge clk);
    #1;
    br_bus = '0; inst_data_ok = 1'b1; inst_rdata = mem_word(out_addr);
    #1;
    check("pre_rst_ce", 64'(if_to_id_bus[32]), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_req", 64'(inst_req), 64'd0);
    check("async_rst_bus", 64'(if_to_id_bus), 64'd0);
    check("async_rst_inst", 64'(if_inst), 64'd0);
    @(posedge clk);
    #1;
    inst_data_ok = 1'b0;
    rst = 1'b0;
    model_reset();
    #3;
    check("post_rst_addr", 64'(inst_addr), 64'(RESET_PC));

    run_random(1500);
    check("handoffs_seen", 64'(handoffs > 300), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Generates the PC and drives the SRAM-like instruction port (req / addr_ok / data_ok).
- Delivers {ce, pc} plus the fetched instruction to the ID stage, which registers them when stall[1] is NoStop.
- Consumes br_bus from ID and applies the redirect after the branch delay slot has been handed off.
- At most one fetch outstanding.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- IF_TO_ID_WD, 33, width of if_to_id_bus ({ce, pc}).
- BR_WD, 33, width of br_bus ({br_e, br_addr}).
- STALL_WD, 6, width of the stall vector (`StallBus).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_WD  pipeline stall vector. [0] = PC stage, [1] = IF/ID register; 1 = Stop.
- br_bus  in  BR_WD  {br_e, br_addr[31:0]} from ID, combinational, may stay high several cycles.
- inst_req  out  1  instruction request valid.
- inst_addr  out  32  request address (= pc).
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.
- if_to_id_bus  out  IF_TO_ID_WD  {ce, pc}; ce = 1 marks a valid instruction.
- if_inst  out  32  instruction matching if_to_id_bus.pc.

Behaviour:
- Registers: pc[31:0], state, inst_buf[31:0], br_pend, br_tgt[31:0].
- Reset (async): pc = RESET_PC, state = REQ, br_pend = 0, br_tgt = 0, inst_buf = 0.
  - While rst = 1: inst_req = 0, if_to_id_bus = 0, if_inst = 0.
  - Reset mid-fetch abandons the outstanding request. The memory side is reset by the same rst, so no stale data_ok arrives.
- States:
  - REQ: inst_req = ~stall[0], inst_addr = pc. If inst_req & inst_addr_ok, go to WAIT. If stall[0] = Stop, no request is issued and state holds.
  - WAIT: inst_req = 0, waiting for data_ok.
    - inst_data_ok & stall[1] = NoStop: handoff this cycle, go to REQ.
    - inst_data_ok & stall[1] = Stop: inst_buf <= inst_rdata, go to HOLD.
    - Otherwise stay in WAIT.
  - HOLD: inst_buf presented. When stall[1] = NoStop: handoff, go to REQ.
- Once issued, a request is never cancelled: stall and branch do not abort WAIT.
- Output valid:
  - valid = (WAIT & inst_data_ok) | HOLD.
  - if_to_id_bus = valid ? {1'b1, pc} : 33'b0.
  - if_inst = HOLD ? inst_buf : (valid ? inst_rdata : 32'b0).
  - While ce = 0, ID latches a bubble.
- Handoff: valid & stall[1] = NoStop. At handoff, pc <= next_pc, where:
  - next_pc = br_e ? br_addr : br_pend ? br_tgt : pc + 4.
  - Addition wraps modulo 2^32.
  - br_pend is cleared at the same handoff.
- Branch capture: any cycle with br_e = 1 and no handoff sets br_pend <= 1 and br_tgt <= br_addr; a repeat br_e overwrites with the same value.
  - br_e with handoff in the same cycle is consumed directly; br_pend is not set.
- Delay slot: the branch's handoff happens before br_e is seen. The next handoff is therefore the delay slot (branch pc + 4), and the redirect applies to the fetch that follows it.
- br_addr is used only when br_e = 1. br_bus = 0 never redirects.
- Throughput: at most one instruction per 2 cycles (addr phase, then data phase). data_ok never occurs in REQ and is ignored there.

Test Plan:
- Reset, then addr_ok one cycle after req and data_ok on the next: inst_addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008. Each handoff shows ce = 1 with the matching pc and if_inst = inst_rdata. ce = 0 in non-data cycles.
- data_ok arrives while stall[1] = Stop for 3 cycles, rdata = 0x3C011234: enter HOLD, if_inst stays 0x3C011234 with ce = 1 for 3 cycles, handoff when stall drops, inst_req stays 0 during HOLD.
- Branch handed off at pc 0xBFC00010, then br_e = 1 with br_addr = 0xBFC00100 for 2 cycles while the delay-slot fetch is in WAIT: delay slot pc 0xBFC00014 is delivered, next inst_addr = 0xBFC00100, br_pend = 0 afterwards.
- br_e = 1 in the same cycle as the delay-slot handoff, br_addr = 0x00000040: next inst_addr = 0x00000040 directly, br_pend never set.
- stall[0] = Stop in REQ for 4 cycles: inst_req = 0 throughout and pc unchanged. addr_ok is withheld for 5 cycles after stall[0] drops: inst_req and inst_addr stay stable.
- Assert rst in WAIT with br_pend = 1: outputs go to 0 immediately (asynchronously). After release the first inst_addr = 0xBFC00000 and there is no redirect.
